matvec_engine: RTL and testbench
================================

MATVEC_ENGINE -- requirements
Module: matvec_engine

Interface
REQ-001 SHALL have parameter ROWS, default 8: matrix A rows, which equals the result count.
REQ-002 SHALL have parameter COLS, default 8: A columns, which equals the B vector length.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: element width.
REQ-004 SHALL have parameter ACC_WIDTH, default 24: accumulator and result width.
REQ-005 SHALL have parameter SIGNED, default 0: 1 means elements and products are two's complement.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port start, input, 1 bit: one-cycle job request.
REQ-009 SHALL have port accum, input, 1 bit: sampled with start; 1 keeps the previous accumulators instead of clearing them.
REQ-010 SHALL have port base_addr, input, 32 bits: word address of the B vector, sampled with start.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the last result is accepted.
REQ-013 SHALL have port address, output, 32 bits: Avalon-MM read address.
REQ-014 SHALL have port read, output, 1 bit: Avalon-MM read request.
REQ-015 SHALL have port readdata, input, COLS*DATA_WIDTH bits: element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port readdatavalid, input, 1 bit: read response valid.
REQ-017 SHALL have port waitrequest, input, 1 bit: slave stall.
REQ-018 SHALL have port res_data, output, ACC_WIDTH bits: result value.
REQ-019 SHALL have port res_idx, output, $clog2(ROWS) bits: row index of res_data.
REQ-020 SHALL have port res_valid, output, 1 bit: result stream valid.
REQ-021 SHALL have port res_ready, input, 1 bit: result stream ready.

Function
REQ-022 SHALL implement the states IDLE -> FETCH -> CALC -> DRAIN -> IDLE.
REQ-023 IDLE: start=1 SHALL latch base_addr and accum and enter FETCH on the next cycle; start SHALL be ignored outside IDLE.
REQ-024 FETCH SHALL issue ROWS+1 reads at base_addr+0 .. base_addr+ROWS; word 0 is B and word r+1 is A row r.
REQ-025 A read SHALL be accepted on a cycle with read=1 and waitrequest=0; address and read SHALL hold stable while waitrequest=1.
REQ-026 Pipelined reads SHALL be issued back-to-back; read SHALL deassert the cycle after the last request is accepted.
REQ-027 The n-th readdatavalid response in FETCH SHALL be stored as word n, in order; readdatavalid outside FETCH SHALL be ignored.
REQ-028 FETCH SHALL exit to CALC on the cycle the (ROWS+1)-th response is captured.
REQ-029 On entering CALC, accumulators SHALL clear unless the latched accum=1.
REQ-030 CALC SHALL take exactly COLS cycles; in cycle k every row r SHALL add A[r][k]*B[k] into acc[r].
REQ-031 Products SHALL be 2*DATA_WIDTH bits, sign- or zero-extended per SIGNED; accumulation SHALL wrap modulo 2^ACC_WIDTH.
REQ-032 DRAIN SHALL present rows 0..ROWS-1 in order with res_valid=1 and res_idx=r.
REQ-033 A result SHALL advance only on res_valid & res_ready; while res_ready=0, res_data and res_idx SHALL hold.
REQ-034 On acceptance of row ROWS-1, the engine SHALL pulse done, drop res_valid and return to IDLE.
REQ-035 The first res_valid SHALL assert in the cycle after the last CALC cycle.
REQ-036 Accumulators SHALL keep their values in IDLE so that accum=1 chains jobs.

Reset
REQ-037 With rst_n=0 at a clock edge, the engine SHALL go to IDLE with read=0, address=0, busy=0, done=0, res_valid=0, res_idx=0, res_data=0, counters=0 and accumulators=0.
REQ-038 Reset in any state, including mid-FETCH with reads outstanding, SHALL abort the job; late responses SHALL be dropped.

Structure
REQ-039 Package matvec_pkg SHALL hold the state enum and the default parameter constants.
REQ-040 One sub-module, matvec_mac, SHALL be instantiated ROWS times, with en, clr, a, b and acc ports and SIGNED and width parameters.
REQ-041 The word buffers SHALL be registers, not a FIFO IP.

Verification
REQ-042 Defaults, B all 1 and A row r all r+1 -> results 8,16,..,64 with res_idx 0..7, then a done pulse.
REQ-043 SIGNED=1, A all 0xFF, B all 0x02 -> every result 0xFFFFF0.
REQ-044 waitrequest high for 3 cycles on the 2nd and 5th reads -> addresses base+0..base+8 each accepted exactly once, results unchanged.
REQ-045 res_ready toggling 1,0,0,1 -> no row dropped or duplicated, and data stable while stalled.
REQ-046 The scenario of REQ-042 run twice, the second with accum=1 -> results 16,32,..,128.
REQ-047 rst_n low in the 3rd CALC cycle, then a fresh job -> outputs at reset values, then correct results.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix-vector engine.
// Holds the controller state encoding and default sizing.
package matvec_pkg;

    localparam int DEF_ROWS       = 8;
    localparam int DEF_COLS       = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_SIGNED     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CALC  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/matvec_mac.sv
// One row multiply-accumulate lane.
// Products are 2*DATA_WIDTH wide, extended to the accumulator width.
module matvec_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] a_x;
    logic [2*DATA_WIDTH-1:0] b_x;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    ext_s;
    logic [ACC_WIDTH-1:0]    ext_u;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH-1:0]    acc_d;
    logic [ACC_WIDTH-1:0]    acc_q;

    // Low 2*DW bits of the extended product are exact for both signednesses
    assign a_x = (SIGNED != 0) ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}
                               : {{DATA_WIDTH{1'b0}}, a};
    assign b_x = (SIGNED != 0) ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b}
                               : {{DATA_WIDTH{1'b0}}, b};
    assign prod  = a_x * b_x;
    assign ext_s = ACC_WIDTH'($signed(prod));
    assign ext_u = ACC_WIDTH'(prod);
    assign prod_ext = (SIGNED != 0) ? ext_s : ext_u;

    always_comb begin
        acc_d = (clr ? '0 : acc_q) + (en ? prod_ext : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en || clr) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector engine: fetches B and the rows of A over Avalon-MM,
// accumulates A*B one column per cycle and streams the row results.
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SIGNED     = DEF_SIGNED
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       accum,
    input  logic [31:0]                base_addr,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                address,
    output logic                       read,
    input  logic [COLS*DATA_WIDTH-1:0] readdata,
    input  logic                       readdatavalid,
    input  logic                       waitrequest,
    output logic [ACC_WIDTH-1:0]       res_data,
    output logic [$clog2(ROWS)-1:0]    res_idx,
    output logic                       res_valid,
    input  logic                       res_ready
);

    localparam int NW = ROWS + 1;
    localparam int CW = $clog2(NW + 1);
    localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IW = $clog2(ROWS);
    localparam int WW = COLS * DATA_WIDTH;

    state_e          state_q, state_d;
    logic            accum_q, accum_d;
    logic            read_q, read_d;
    logic [31:0]     addr_q, addr_d;
    logic [CW-1:0]   req_q, req_d;
    logic [CW-1:0]   rsp_q, rsp_d;
    logic [KW-1:0]   k_q, k_d;
    logic [IW-1:0]   row_q, row_d;
    logic            done_q, done_d;
    logic            vld_q, vld_d;
    logic            wr_en;
    logic            mac_en;
    logic            mac_clr;

    logic [WW-1:0]         words_q [NW];
    logic [DATA_WIDTH-1:0] b_elem;
    logic [ACC_WIDTH-1:0]  acc [ROWS];

    always_comb begin
        state_d = state_q;
        accum_d = accum_q;
        read_d  = read_q;
        addr_d  = addr_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
        k_d     = k_q;
        row_d   = row_q;
        done_d  = 1'b0;
        vld_d   = vld_q;
        wr_en   = 1'b0;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    accum_d = accum;
                    addr_d  = base_addr;
                    read_d  = 1'b1;
                    req_d   = '0;
                    rsp_d   = '0;
                end
            end
            ST_FETCH: begin
                if (read_q && !waitrequest) begin
                    req_d = req_q + 1'b1;
                    if (req_q == CW'(ROWS)) begin
                        read_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 32'd1;
                    end
                end
                if (readdatavalid) begin
                    wr_en = 1'b1;
                    rsp_d = rsp_q + 1'b1;
                    if (rsp_q == CW'(ROWS)) begin
                        state_d = ST_CALC;
                        read_d  = 1'b0;
                        k_d     = '0;
                    end
                end
            end
            ST_CALC: begin
                mac_en  = 1'b1;
                mac_clr = (k_q == '0) && !accum_q;
                k_d     = k_q + 1'b1;
                if (k_q == KW'(COLS - 1)) begin
                    state_d = ST_DRAIN;
                    row_d   = '0;
                    vld_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (res_ready) begin
                    if (row_q == IW'(ROWS - 1)) begin
                        state_d = ST_IDLE;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            accum_q <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
            k_q     <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            accum_q <= accum_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            k_q     <= k_d;
            row_q   <= row_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
        end
    end

    // Word 0 holds B, word r+1 holds row r of A
    always_ff @(posedge clk) begin
        if (wr_en) begin
            words_q[rsp_q] <= readdata;
        end
    end

    assign b_elem = words_q[0][k_q*DATA_WIDTH +: DATA_WIDTH];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH-1:0] a_elem;
        assign a_elem = words_q[r+1][k_q*DATA_WIDTH +: DATA_WIDTH];
        matvec_mac #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SIGNED     (SIGNED)
        ) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (mac_en),
            .clr   (mac_clr),
            .a     (a_elem),
            .b     (b_elem),
            .acc   (acc[r])
        );
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign address   = addr_q;
    assign read      = read_q;
    assign res_data  = acc[row_q];
    assign res_idx   = row_q;
    assign res_valid = vld_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Bench for matvec_engine: unsigned and signed instances share one
// Avalon slave model; results are compared with a plain arithmetic model.
module tb_matvec_engine;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int WW = C * DW;
    localparam longint MASK = (longint'(1) << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          accum;
    logic [31:0]   base_addr;
    logic [WW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;
    logic          res_ready;

    logic          busy_u, done_u, read_u, res_valid_u;
    logic [31:0]   address_u;
    logic [AW-1:0] res_data_u;
    logic [2:0]    res_idx_u;
    logic          busy_s, done_s, read_s, res_valid_s;
    logic [31:0]   address_s;
    logic [AW-1:0] res_data_s;
    logic [2:0]    res_idx_s;

    always #5 clk = ~clk;

    matvec_engine #(
        .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .accum(accum),
        .base_addr(base_addr), .busy(busy_u), .done(done_u),
        .address(address_u), .read(read_u), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .res_data(res_data_u), .res_idx(res_idx_u),
        .res_valid(res_valid_u), .res_ready(res_ready)
    );

    matvec_engine #(
        .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1)
    ) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .accum(accum),
        .base_addr(base_addr), .busy(busy_s), .done(done_s),
        .address(address_s), .read(read_s), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .res_data(res_data_s), .res_idx(res_idx_s),
        .res_valid(res_valid_s), .res_ready(res_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [WW-1:0] mem [64];
    longint        exp_u [R];
    longint        exp_s [R];

    // Avalon slave model
    int          stall_mode = 0;
    int          stall_left = 0;
    int          n_acc = 0;
    int          rsp_given = 0;
    logic        stalling = 1'b0;
    logic [31:0] stall_addr = '0;
    logic [31:0] addr_log [$];
    logic [31:0] pend [$];

    always @(negedge clk) begin : slave
        logic        prev;
        logic [31:0] a;
        prev = stalling;
        stalling = 1'b0;
        waitrequest = 1'b0;
        if (!rst_n) begin
            stall_left = 0;
        end else if (prev) begin
            check("rd_hold", read_u, 1);
            check("addr_hold", address_u, stall_addr);
        end
        if (!busy_u) begin
            n_acc = 0;
            rsp_given = 0;
        end
        if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            a = pend.pop_front();
            readdata = mem[a[5:0]];
            readdatavalid = 1'b1;
            rsp_given++;
        end else begin
            readdata = {$urandom, $urandom};
            readdatavalid = 1'b0;
        end
        if (rst_n && read_u) begin
            if (stall_left > 0) begin
                if (!prev) stall_addr = address_u;
                waitrequest = 1'b1;
                stalling = 1'b1;
                stall_left--;
            end else begin
                addr_log.push_back(address_u);
                pend.push_back(address_u);
                n_acc++;
                if (stall_mode == 1 && (n_acc == 1 || n_acc == 4))
                    stall_left = 3;
                else if (stall_mode == 2)
                    stall_left = $urandom_range(0, 2);
            end
        end
    end

    // Result sink
    int            rdy_mode = 0;
    int            rdy_ph = 0;
    int            done_cnt = 0;
    int            done_cnt_s = 0;
    logic          hold_v = 1'b0;
    logic [2:0]    h_idx;
    logic [AW-1:0] h_dat, h_dat_s;
    logic [63:0]   got_idx [$];
    logic [63:0]   got_u [$];
    logic [63:0]   got_s [$];

    always @(negedge clk) begin : sink
        if (rst_n && hold_v) begin
            check("res_hold_v", res_valid_u, 1);
            check("res_hold_idx", res_idx_u, h_idx);
            check("res_hold_data", res_data_u, h_dat);
            check("res_hold_data_s", res_data_s, h_dat_s);
        end
        hold_v = 1'b0;
        if (!busy_u) rdy_ph = 0;
        case (rdy_mode)
            1: res_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
            2: res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b1;
        endcase
        if (rst_n && res_valid_u) begin
            rdy_ph++;
            if (res_ready) begin
                got_idx.push_back({61'd0, res_idx_u});
                got_u.push_back({40'd0, res_data_u});
                got_s.push_back({40'd0, res_data_s});
            end else begin
                hold_v = 1'b1;
                h_idx = res_idx_u;
                h_dat = res_data_u;
                h_dat_s = res_data_s;
            end
        end
        if (rst_n && done_u) done_cnt++;
        if (rst_n && done_s) done_cnt_s++;
    end

    task automatic model(input int base, input bit acc);
        logic [DW-1:0] av, bv;
        for (int r = 0; r < R; r++) begin
            longint su = 0;
            longint ss = 0;
            for (int k = 0; k < C; k++) begin
                bv = mem[base][k*DW +: DW];
                av = mem[base+1+r][k*DW +: DW];
                su += longint'(av) * longint'(bv);
                ss += longint'($signed(av)) * longint'($signed(bv));
            end
            exp_u[r] = ((acc ? exp_u[r] : 0) + su) & MASK;
            exp_s[r] = ((acc ? exp_s[r] : 0) + ss) & MASK;
        end
    endtask

    task automatic pulse_start(input int base, input bit acc);
        start = 1'b1;
        base_addr = 32'(base);
        accum = acc;
        @(negedge clk);
        start = 1'b0;
        base_addr = $urandom;
        accum = 1'($urandom);
    endtask

    task automatic run_job(input int base, input bit acc, input int smode,
                           input int rmode, input bit spurious);
        int a0, g0, d0, d0s, t;
        model(base, acc);
        stall_mode = smode;
        rdy_mode = rmode;
        a0 = addr_log.size();
        g0 = got_u.size();
        d0 = done_cnt;
        d0s = done_cnt_s;
        @(negedge clk);
        pulse_start(base, acc);
        if (spurious) begin
            repeat (3) @(negedge clk);
            pulse_start((base + 23) % 48, !acc);
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("done_pulses_s", done_cnt_s - d0s, 1);
        check("busy_after", busy_u, 0);
        check("n_reads", addr_log.size() - a0, R + 1);
        for (int i = 0; i < R + 1 && a0 + i < addr_log.size(); i++)
            check("rd_addr", addr_log[a0+i], 64'(base + i));
        check("n_results", got_u.size() - g0, R);
        for (int r = 0; r < R && g0 + r < got_u.size(); r++) begin
            check("res_idx", got_idx[g0+r], 64'(r));
            check("res_u", got_u[g0+r], exp_u[r]);
            check("res_s", got_s[g0+r], exp_s[r]);
        end
        stall_mode = 0;
        rdy_mode = 0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_u, 0);
        check("rst_busy_s", busy_s, 0);
        check("rst_done", done_u, 0);
        check("rst_read", read_u, 0);
        check("rst_addr", address_u, 0);
        check("rst_vld", res_valid_u, 0);
        check("rst_idx", res_idx_u, 0);
        check("rst_data", res_data_u, 0);
        check("rst_data_s", res_data_s, 0);
        rst_n = 1'b1;
        for (int r = 0; r < R; r++) begin
            exp_u[r] = 0;
            exp_s[r] = 0;
        end
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        accum = 1'b0;
        base_addr = '0;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
        reset_dut();

        mem[8] = {C{8'h01}};
        for (int r = 0; r < R; r++) mem[9+r] = {C{8'(r + 1)}};
        mem[20] = {C{8'h02}};
        for (int r = 0; r < R; r++) mem[21+r] = {C{8'hFF}};

        run_job(8, 0, 0, 0, 0);
        run_job(8, 1, 0, 0, 0);
        run_job(20, 0, 0, 0, 0);
        run_job(8, 0, 1, 0, 0);
        run_job(8, 0, 0, 1, 0);
        run_job(20, 0, 1, 1, 1);

        // abort in the third CALC cycle
        @(negedge clk);
        pulse_start(8, 0);
        t = 0;
        while (rsp_given < R + 1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("calc_reached", t < 500, 1);
        repeat (2) @(negedge clk);
        reset_dut();
        run_job(8, 1, 0, 0, 0);

        // abort mid-FETCH with responses still in flight
        @(negedge clk);
        pulse_start(20, 0);
        repeat (4) @(negedge clk);
        reset_dut();
        repeat (20) @(negedge clk);
        run_job(20, 0, 2, 2, 0);

        for (int j = 0; j < 20; j++) begin
            int b;
            b = $urandom_range(0, 63 - R);
            for (int i = 0; i <= R; i++) mem[b+i] = {$urandom, $urandom};
            run_job(b, 1'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 2), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
